// File: rtl/seq_shift_add_multiplier.sv
// Iterative shift-and-add multiplier: one operand pair per job, WIDTH accumulate
// cycles, result held under valid/ready until the consumer takes it.
//
// state  | meaning
// IDLE   | waiting for an operand pair (in_ready=1)
// RUN    | accumulating one partial product per cycle
// DONE   | product valid, waiting for out_ready
module seq_shift_add_multiplier #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic                 is_signed,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   product
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [WIDTH-1:0]     r_mcand;
    logic [WIDTH-1:0]     r_mplier;
    logic [2*WIDTH-1:0]   r_acc;
    logic [CNT_W-1:0]     r_cnt;
    logic                 r_neg;

    logic [WIDTH-1:0]     w_mag_a;
    logic [WIDTH-1:0]     w_mag_b;
    logic [2*WIDTH-1:0]   w_addend;
    logic [2*WIDTH-1:0]   w_acc_nxt;
    logic                 w_last;

    // Magnitude of -2^(WIDTH-1) wraps to 2^(WIDTH-1), which is correct as unsigned.
    assign w_mag_a   = (is_signed && a[WIDTH-1]) ? (~a + WIDTH'(1)) : a;
    assign w_mag_b   = (is_signed && b[WIDTH-1]) ? (~b + WIDTH'(1)) : b;
    assign w_addend  = r_mplier[0] ? ({{WIDTH{1'b0}}, r_mcand} << r_cnt) : '0;
    assign w_acc_nxt = r_acc + w_addend;
    assign w_last    = (r_cnt == CNT_W'(WIDTH - 1));

    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = (r_state == S_DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (in_valid)  w_state_nxt = S_RUN;
            S_RUN:   if (w_last)    w_state_nxt = S_DONE;
            S_DONE:  if (out_ready) w_state_nxt = S_IDLE;
            default:                w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_neg    <= 1'b0;
            product  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_mcand  <= w_mag_a;
                        r_mplier <= w_mag_b;
                        r_neg    <= is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
                        r_acc    <= '0;
                        r_cnt    <= '0;
                    end
                end
                S_RUN: begin
                    r_acc    <= w_acc_nxt;
                    r_mplier <= r_mplier >> 1;
                    r_cnt    <= r_cnt + CNT_W'(1);
                    // Negating a zero accumulator yields zero, so no negative zero.
                    if (w_last) begin
                        product <= r_neg ? -w_acc_nxt : w_acc_nxt;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_shift_add_multiplier.sv
// Bench for seq_shift_add_multiplier: three instances (WIDTH 8, 16, 3) checked every
// cycle against a job-level model, plus directed jobs with literal products.
module tb_seq_shift_add_multiplier;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [2:0]  iv, ordy, sgn, ir, ov;
    logic [15:0] in_a [3];
    logic [15:0] in_b [3];
    logic [15:0] p8;
    logic [31:0] p16;
    logic [5:0]  p3;

    seq_shift_add_multiplier #(.WIDTH(8)) u_w8 (
        .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]),
        .a(in_a[0][7:0]), .b(in_b[0][7:0]), .is_signed(sgn[0]),
        .out_valid(ov[0]), .out_ready(ordy[0]), .product(p8));

    seq_shift_add_multiplier #(.WIDTH(16)) u_w16 (
        .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]),
        .a(in_a[1]), .b(in_b[1]), .is_signed(sgn[1]),
        .out_valid(ov[1]), .out_ready(ordy[1]), .product(p16));

    seq_shift_add_multiplier #(.WIDTH(3)) u_w3 (
        .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ir[2]),
        .a(in_a[2][2:0]), .b(in_b[2][2:0]), .is_signed(sgn[2]),
        .out_valid(ov[2]), .out_ready(ordy[2]), .product(p3));

    int n_checks = 0;
    int n_fail   = 0;

    // Job-level model: 0 = idle, 1 = busy for m_left more edges, 2 = result pending.
    int     m_st   [3];
    int     m_left [3];
    longint m_exp  [3];
    longint m_prod [3];
    longint sq     [3][$];
    int     n_acc  [3];
    int     n_hs   [3];

    function automatic int wid(int i);
        return (i == 0) ? 8 : (i == 1) ? 16 : 3;
    endfunction

    function automatic longint mask(int w);
        return (longint'(1) << w) - 1;
    endfunction

    function automatic longint ref_prod(int w, longint x, longint y, bit s);
        longint sx, sy;
        sx = x & mask(w);
        sy = y & mask(w);
        if (s && sx[w-1]) sx = sx - (longint'(1) << w);
        if (s && sy[w-1]) sy = sy - (longint'(1) << w);
        return (sx * sy) & mask(2 * w);
    endfunction

    function automatic longint act_prod(int i);
        if (i == 0) return longint'(p8);
        if (i == 1) return longint'(p16);
        return longint'(p3);
    endfunction

    task automatic check(string name, longint act, longint exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            m_st[i]   = 0;
            m_left[i] = 0;
            m_exp[i]  = 0;
            m_prod[i] = 0;
            sq[i].delete();
        end
    endtask

    // One clock: scoreboard and model advance on the edge, outputs compared at negedge.
    task automatic tick();
        logic [2:0] p_ir, p_ov;
        longint     p_prod [3];
        longint     expv;
        p_ir = ir;
        p_ov = ov;
        for (int i = 0; i < 3; i++) p_prod[i] = act_prod(i);
        @(posedge clk);
        for (int i = 0; i < 3; i++) begin
            if (iv[i] && p_ir[i]) begin
                sq[i].push_back(ref_prod(wid(i), longint'(in_a[i]), longint'(in_b[i]), sgn[i]));
                n_acc[i]++;
            end
            if (p_ov[i] && ordy[i]) begin
                n_hs[i]++;
                if (sq[i].size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL sb_w%0d: product 0x%0h delivered with no job outstanding", wid(i), p_prod[i]);
                end else begin
                    expv = sq[i].pop_front();
                    check($sformatf("sb_w%0d", wid(i)), p_prod[i], expv);
                end
            end
            case (m_st[i])
                0: if (iv[i]) begin
                    m_exp[i]  = ref_prod(wid(i), longint'(in_a[i]), longint'(in_b[i]), sgn[i]);
                    m_left[i] = wid(i);
                    m_st[i]   = 1;
                end
                1: begin
                    m_left[i]--;
                    if (m_left[i] == 0) begin
                        m_st[i]   = 2;
                        m_prod[i] = m_exp[i];
                    end
                end
                default: if (ordy[i]) m_st[i] = 0;
            endcase
        end
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("in_ready_w%0d", wid(i)), longint'(ir[i]), longint'(m_st[i] == 0));
            check($sformatf("out_valid_w%0d", wid(i)), longint'(ov[i]), longint'(m_st[i] == 2));
            check($sformatf("product_w%0d", wid(i)), act_prod(i), m_prod[i]);
        end
    endtask

    task automatic wait_done8(string name);
        int n;
        n = 0;
        while (!ov[0] && n < 40) begin
            tick();
            n++;
        end
        check({name, "_latency"}, n, 8);
    endtask

    task automatic job8(string name, logic [7:0] x, logic [7:0] y, bit s, logic [15:0] exp);
        in_a[0] = {8'h00, x};
        in_b[0] = {8'h00, y};
        sgn[0]  = s;
        iv[0]   = 1'b1;
        ordy[0] = 1'b0;
        tick();
        iv[0]   = 1'b0;
        in_a[0] = 16'($urandom_range(0, 255));
        in_b[0] = 16'($urandom_range(0, 255));
        sgn[0]  = ~s;
        wait_done8(name);
        check({name, "_prod"}, longint'(p8), longint'(exp));
        ordy[0] = 1'b1;
        tick();
        ordy[0] = 1'b0;
    endtask

    int issued [3];
    int prev_acc [3];
    int cyc;

    initial begin
        iv = '0; ordy = '0; sgn = '0;
        for (int i = 0; i < 3; i++) begin
            in_a[i] = '0; in_b[i] = '0;
            n_acc[i] = 0; n_hs[i] = 0; issued[i] = 0;
        end
        model_reset();
        #3;
        check("reset_in_ready", longint'(ir), 7);
        check("reset_out_valid", longint'(ov), 0);
        check("reset_p8", longint'(p8), 0);
        check("reset_p16", longint'(p16), 0);
        check("reset_p3", longint'(p3), 0);
        @(negedge clk);
        rst = 1'b0;

        job8("u_ff_ff",    8'hFF, 8'hFF, 1'b0, 16'hFE01);
        job8("s_m128sq",   8'h80, 8'h80, 1'b1, 16'h4000);
        job8("s_m3x5",     8'hFD, 8'h05, 1'b1, 16'hFFF1);
        job8("s_m128x127", 8'h80, 8'h7F, 1'b1, 16'hC080);
        job8("mode_u",     8'h80, 8'h02, 1'b0, 16'h0100);
        job8("mode_s",     8'h80, 8'h02, 1'b1, 16'hFF00);
        job8("s_zero",     8'h00, 8'h85, 1'b1, 16'h0000);

        // Backpressure: result must hold while inputs churn.
        in_a[0] = 16'h000C; in_b[0] = 16'h000B; sgn[0] = 1'b0; iv[0] = 1'b1;
        tick();
        iv[0] = 1'b0;
        wait_done8("bp");
        for (int k = 0; k < 5; k++) begin
            ordy[0] = 1'b0;
            iv[0]   = k[0];
            in_a[0] = 16'($urandom_range(0, 255));
            in_b[0] = 16'($urandom_range(0, 255));
            tick();
            check("bp_hold_prod", longint'(p8), 16'h0084);
            check("bp_hold_valid", longint'(ov[0]), 1);
            check("bp_hold_ready", longint'(ir[0]), 0);
        end
        in_a[0] = 16'h0003; in_b[0] = 16'h0005; sgn[0] = 1'b0;
        iv[0] = 1'b1; ordy[0] = 1'b1;
        tick();
        check("bp_idle_after_hs", longint'(ir[0]), 1);
        ordy[0] = 1'b0;
        tick();
        check("bp_next_accept", longint'(ir[0]), 0);
        iv[0] = 1'b0;
        wait_done8("bp_next");
        check("bp_next_prod", longint'(p8), 16'h000F);
        ordy[0] = 1'b1;
        tick();
        ordy[0] = 1'b0;

        // Asynchronous reset three cycles into a job.
        in_a[0] = 16'h0055; in_b[0] = 16'h0033; sgn[0] = 1'b0; iv[0] = 1'b1;
        tick();
        iv[0] = 1'b0;
        repeat (3) tick();
        #2 rst = 1'b1;
        #1;
        check("rst_in_ready", longint'(ir[0]), 1);
        check("rst_out_valid", longint'(ov[0]), 0);
        check("rst_product", longint'(p8), 0);
        model_reset();
        #1 rst = 1'b0;
        job8("after_rst_7x6", 8'h07, 8'h06, 1'b0, 16'h002A);

        // Random streams on WIDTH=16 and WIDTH=3 with stalls on both sides.
        for (int i = 0; i < 3; i++) prev_acc[i] = n_acc[i];
        cyc = 0;
        while ((n_hs[1] < 400 || n_hs[2] < 400) && cyc < 30000) begin
            for (int i = 1; i < 3; i++) begin
                if (n_acc[i] != prev_acc[i]) iv[i] = 1'b0;
                if (!iv[i] && issued[i] < 400 && $urandom_range(0, 3) != 0) begin
                    in_a[i] = 16'($urandom) & 16'(mask(wid(i)));
                    in_b[i] = 16'($urandom) & 16'(mask(wid(i)));
                    sgn[i]  = issued[i][0];
                    iv[i]   = 1'b1;
                    issued[i]++;
                end
                ordy[i] = ($urandom_range(0, 3) != 0);
                prev_acc[i] = n_acc[i];
            end
            tick();
            cyc++;
        end
        for (int i = 1; i < 3; i++) begin
            check($sformatf("rand_handshakes_w%0d", wid(i)), n_hs[i], 400);
            check($sformatf("rand_accepts_w%0d", wid(i)), n_acc[i], 400);
            check($sformatf("rand_leftover_w%0d", wid(i)), sq[i].size(), 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
